// File: rtl/axis_rx_arbiter.sv
// axis_rx_arbiter: packet-granular round-robin arbiter sharing one AXI-Stream RX path
module axis_rx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PORTS  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS-1:0]            port_en,
    output logic                            m_tvalid,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_tkeep,
    output logic                            m_tlast,
    input  logic                            m_tready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                               state, state_d;
    logic [PW-1:0]                        owner, sel, rr_ptr;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  cnt;
    logic [NUM_PORTS-1:0]                 req;
    logic                                 locked, done;

    assign req       = s_tvalid & port_en;
    assign locked    = state == LOCKED;
    assign done      = locked && m_tvalid && m_tready && m_tlast;
    assign pkt_count = cnt;

    // first requester at or after rr_ptr; scanning downward lets the nearest one win
    always_comb begin
        sel = rr_ptr;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (req[(int'(rr_ptr) + i) % NUM_PORTS]) sel = PW'((int'(rr_ptr) + i) % NUM_PORTS);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    // lock on any request in IDLE, release once the tlast beat handshakes
    always_comb
        state_d = (state == IDLE) ? (|req ? LOCKED : IDLE) : (done ? IDLE : LOCKED);

    // owner capture, round-robin pointer advance and per-port packet counters
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && |req) owner <= sel;
            if (done) begin
                rr_ptr     <= (owner == PW'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
                cnt[owner] <= cnt[owner] + 1'b1;
            end
        end

    // combinational pass-through of the owner while locked, all quiet when idle
    always_comb begin
        m_tvalid = locked & s_tvalid[owner];
        m_tdata  = locked ? s_tdata[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
        m_tkeep  = locked ? s_tkeep[owner*KW +: KW] : '0;
        m_tlast  = locked & s_tlast[owner];
        s_tready = locked ? (NUM_PORTS'(m_tready) << owner) : '0;
        grant    = locked ? (NUM_PORTS'(1) << owner) : '0;
        busy     = locked;
    end
endmodule

// File: doc/axis_rx_arbiter.md
Name: axis_rx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single AXI-Stream RX path (the byte-compacting receive stage and parser behind it) between NUM_PORTS upstream stream sources.
- Grants one port per packet, passes that port's beats straight through, and releases the grant only after the tlast beat handshakes.
- Sits between the MAC/DMA-side stream sources and the RX compaction stage; backpressure comes from m_tready, which the downstream stage drives from its parser_ready.

Parameters:
- DATA_WIDTH, 64, stream data width in bits; multiple of 8.
- NUM_PORTS, 2, number of upstream stream sources; >= 2.
- CNT_WIDTH, 16, width of each per-port completed-packet counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_tvalid  in  NUM_PORTS  per-port beat valid.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data; port p occupies [p*DATA_WIDTH +: DATA_WIDTH].
- s_tkeep  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables, packed the same way.
- s_tlast  in  NUM_PORTS  per-port end-of-packet.
- s_tready  out  NUM_PORTS  per-port ready.
- port_en  in  NUM_PORTS  per-port arbitration enable.
- m_tvalid  out  1  muxed beat valid to the RX stage.
- m_tdata  out  DATA_WIDTH  muxed data.
- m_tkeep  out  DATA_WIDTH/8  muxed byte enables.
- m_tlast  out  1  muxed end-of-packet.
- m_tready  in  1  downstream ready.
- grant  out  NUM_PORTS  one-hot current owner; all zero when idle.
- busy  out  1  high while a packet is locked.
- pkt_count  out  NUM_PORTS*CNT_WIDTH  per-port completed-packet counters.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, grant=0, busy=0, rr_ptr=0, all pkt_count=0.
- Outputs during reset: m_tvalid=0, s_tready=0, m_tdata/m_tkeep/m_tlast=0.

State machine (2 states, IDLE and LOCKED):
- IDLE:
  - m_tvalid=0, all s_tready=0, m_tdata/m_tkeep/m_tlast driven 0.
  - req = s_tvalid & port_en.
  - If req!=0: pick the first set bit of req at index rr_ptr, rr_ptr+1, ... (mod NUM_PORTS). Register grant as one-hot of that port, set busy=1, go to LOCKED.
  - If req==0: stay in IDLE.
- LOCKED, with owner g:
  - m_tvalid=s_tvalid[g], m_tdata/m_tkeep/m_tlast = port g's fields, s_tready[g]=m_tready. All other s_tready=0.
  - The pass-through is purely combinational: zero latency, no buffering.
  - On (m_tvalid & m_tready & m_tlast): next cycle state=IDLE, grant=0, busy=0, rr_ptr=(g+1) mod NUM_PORTS, pkt_count[g]+=1.
  - Non-last handshakes leave state unchanged.

Timing and arbitration rules:
- Arbitration latency: a request seen in IDLE at cycle n is granted at cycle n+1; its first beat can handshake in cycle n+1.
- There is exactly one idle bubble cycle between back-to-back packets.
- A port is never granted mid-packet. Grant changes only in IDLE.
- port_en deassertion while LOCKED does not abort the current packet; it only affects the next arbitration.
- s_tvalid dropping mid-packet on the owner stalls: m_tvalid=0 and the lock is held.
- Single-beat packets (tlast on the first beat) are supported: LOCKED lasts one cycle if m_tready=1.
- m_tready low holds all outputs stable for the owner, per AXI-Stream rules.
- tkeep is not inspected or modified.

Arithmetic and reset:
- pkt_count wraps modulo 2^CNT_WIDTH, with no saturation.
- rr_ptr increments modulo NUM_PORTS, with explicit wrap for non-power-of-2 NUM_PORTS.
- Reset asserted mid-packet: return to IDLE immediately. The remainder of the packet is the source's problem; the arbiter does not resume it.

Test Plan:
- Reset, then port0 sends 3 beats (tlast on beat 3) with m_tready=1 -> grant=01 one cycle after request; beats appear on m_* unchanged; pkt_count[0]=1; idle cycle; grant=00.
- Both ports request continuously with 2-beat packets -> grant order 0,1,0,1 with one bubble between packets; after 4 packets pkt_count[0]=2 and pkt_count[1]=2.
- Port1 owns a packet; port0 asserts tvalid mid-packet -> s_tready[0]=0 until port1's tlast handshakes; port0 is granted next.
- m_tready toggles 1,0,0,1 during a packet -> beats are neither dropped nor duplicated; m_tdata stays stable while stalled; grant is held.
- port_en=01 while both request -> only port0 is ever granted. Clearing port_en[0] mid-packet -> the packet completes; next arbitration is idle.
- Assert rst_n=0 mid-packet -> grant=0, busy=0, counters=0, m_tvalid=0 asynchronously. After release, a fresh request is granted at port 0 first (rr_ptr=0).
- CNT_WIDTH=4, 17 packets on port0 -> pkt_count[0]=1.
